fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register. It sits directly upstream of the control unit and drives the 7-bit opcode the control unit decodes.
- Reads a 16-bit-wide instruction memory and assembles two-word (immediate) instructions.
- Loads the PC from a reset vector, handles stall/redirect, and stops fetching on HLT.

Parameters:
- ADDR_W, 20, PC / instruction-address width. Legal range 17..32.
- HLT_OP, 7'b1100001, opcode that halts fetch.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- imem_addr  out  ADDR_W  instruction memory word address. Combinational from state/PC.
- imem_data  in  16  instruction memory word. Combinational read, valid in the same cycle as imem_addr.
- stall  in  1  hold the IF/ID register and PC (hazard from downstream).
- redirect_valid  in  1  branch/jump/interrupt redirect request.
- redirect_pc  in  ADDR_W  redirect target.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  16  first instruction word.
- if_id_imm  out  16  second word of a two-word instruction; 0 for one-word instructions.
- if_id_pc  out  ADDR_W  address of the first word.
- opcode  out  7  if_id_instr[15:9], feeds the control unit.
- halted  out  1  high while in HALT.
- stall_cycles  out  32  stall counter (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high): state=RST_VEC0, pc=0, hold_word=0. All IF/ID outputs, opcode and halted are 0. Reset dominates all other inputs; asserted mid-fetch, it discards any held first word.
- Two-word rule: opcode bits [6:5]==2'b01 means the instruction has one 16-bit immediate word following it (IADD, LDM, LDD, STD). All other opcodes are one word.
- States: RST_VEC0, RST_VEC1, FETCH, FETCH_IMM, HALT.
- RST_VEC0:
  - imem_addr=0; pc[15:0]<=imem_data; next state RST_VEC1; if_id_valid=0.
  - Stall and redirect are ignored.
- RST_VEC1:
  - imem_addr=1; pc[ADDR_W-1:16]<=imem_data[ADDR_W-17:0]; next state FETCH; if_id_valid=0.
  - Stall and redirect are ignored.
- FETCH (imem_addr=pc):
  - redirect_valid: pc<=redirect_pc; if_id_valid<=0; stay in FETCH. Redirect beats stall.
  - Else stall: pc, state and all IF/ID outputs hold.
  - Else two-word opcode: hold_word<=imem_data; pc<=pc+1; if_id_valid<=0 (bubble); next state FETCH_IMM.
  - Else one-word: if_id_instr<=imem_data; if_id_imm<=0; if_id_pc<=pc; if_id_valid<=1; pc<=pc+1. If the opcode is HLT_OP, next state HALT, otherwise stay in FETCH.
- FETCH_IMM (imem_addr=pc):
  - redirect_valid: drop hold_word; pc<=redirect_pc; if_id_valid<=0; next state FETCH.
  - Else stall: hold everything.
  - Else: if_id_instr<=hold_word; if_id_imm<=imem_data; if_id_pc<=pc-1; if_id_valid<=1; pc<=pc+1; next state FETCH.
- HALT:
  - if_id_valid<=0 on entry+1; halted=1; pc frozen; imem_addr=pc.
  - redirect_valid (from an older in-flight branch): pc<=redirect_pc; next state FETCH; halted<=0. Otherwise only reset exits HALT.
- Outputs are registered with 1-cycle latency from address to IF/ID. opcode always equals if_id_instr[15:9].
- PC arithmetic is modulo 2^ADDR_W; all-ones+1 wraps to 0, including the pc-1 for if_id_pc.
- While stalled, if_id_valid and the data outputs are stable.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- Defined:
  - stall_cycles is a 32-bit counter, cleared by reset.
  - Increments each cycle in which stall=1 and redirect_valid=0 and state is FETCH or FETCH_IMM.
  - Saturates at 32'hFFFFFFFF.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Reset vector: mem[0]=16'h0040, mem[1]=16'h0000, mem[0x40]=ADD (opcode 0000001). After reset release, the 3rd rising edge gives if_id_valid=1, if_id_pc=0x40, opcode=7'b0000001.
- Two-word: mem[0x40]=LDM word, mem[0x41]=16'hBEEF. Expect a bubble cycle, then if_id_valid=1, if_id_pc=0x40, if_id_imm=16'hBEEF; next fetch address is 0x42.
- Stall: assert stall for 3 cycles mid-stream. Outputs and imem_addr are frozen; stall_cycles=3 with FETCH_STALL_CNT_EN, else 0.
- Redirect in FETCH_IMM with stall also high, redirect_pc=0x100. hold_word is discarded, if_id_valid=0, next fetch is 0x100, and the next valid instruction has if_id_pc=0x100.
- HLT at 0x50: if_id_valid=1 with opcode 1100001, then halted=1, if_id_valid=0 and the PC is frozen. redirect to 0x60 resumes fetch at 0x60.
- Wrap and reset: pc=2^ADDR_W-1 holds a one-word instruction; next address is 0. Reset asserted in FETCH_IMM returns to RST_VEC0 with all outputs 0.

Source files
------------

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : instruction fetch + IF/ID register, two-word immediate assembly
// Optional stall counter built when FETCH_STALL_CNT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter int         ADDR_W = 20,
  parameter logic [6:0] HLT_OP = 7'b1100001
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_id_valid,
  output logic [15:0]       if_id_instr,
  output logic [15:0]       if_id_imm,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [6:0]        opcode,
  output logic              halted,
  output logic [31:0]       stall_cycles
);

  typedef enum logic [2:0] {
    RST_VEC0  = 3'd0,
    RST_VEC1  = 3'd1,
    FETCH     = 3'd2,
    FETCH_IMM = 3'd3,
    HALT      = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       hold_q, hold_d;
  logic              valid_q, valid_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       imm_q, imm_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic              two_word;

  // Opcode bits [6:5] == 01 marks an instruction followed by an immediate word.
  assign two_word = (imem_data[15:14] == 2'b01);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST_VEC0;
      pc_q    <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      imm_q   <= '0;
      ifpc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      imm_q   <= imm_d;
      ifpc_q  <= ifpc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    ifpc_d    = ifpc_q;
    imem_addr = pc_q;
    case (state_q)
      RST_VEC0: begin
        imem_addr  = '0;
        pc_d[15:0] = imem_data;
        valid_d    = 1'b0;
        state_d    = RST_VEC1;
      end
      RST_VEC1: begin
        imem_addr          = PC_ONE;
        pc_d[ADDR_W-1:16]  = imem_data[ADDR_W-17:0];
        valid_d            = 1'b0;
        state_d            = FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (!stall) begin
          pc_d = pc_q + PC_ONE;
          if (two_word) begin
            hold_d  = imem_data;
            valid_d = 1'b0;
            state_d = FETCH_IMM;
          end else begin
            instr_d = imem_data;
            imm_d   = '0;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            if (imem_data[15:9] == HLT_OP) state_d = HALT;
          end
        end
      end
      FETCH_IMM: begin
        if (redirect_valid) begin
          hold_d  = '0;
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (!stall) begin
          instr_d = hold_q;
          imm_d   = imem_data;
          ifpc_d  = pc_q - PC_ONE;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_ONE;
          state_d = FETCH;
        end
      end
      HALT: begin
        valid_d = 1'b0;
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = FETCH;
        end
      end
      default: state_d = RST_VEC0;
    endcase
  end

  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_imm   = imm_q;
  assign if_id_pc    = ifpc_q;
  assign opcode      = instr_q[15:9];
  assign halted      = (state_q == HALT);

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && !redirect_valid &&
                 (state_q == FETCH || state_q == FETCH_IMM) &&
                 (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : directed self-checking bench for fetch_stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam int ADDR_W = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_data;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_id_valid;
  logic [15:0]       if_id_instr;
  logic [15:0]       if_id_imm;
  logic [ADDR_W-1:0] if_id_pc;
  logic [6:0]        opcode;
  logic              halted;
  logic [31:0]       stall_cycles;

  int checks = 0;
  int errors = 0;

`ifdef FETCH_STALL_CNT_EN
  localparam logic [31:0] EXP_STALL3 = 32'd3;
`else
  localparam logic [31:0] EXP_STALL3 = 32'd0;
`endif

  logic [15:0] mem [logic [ADDR_W-1:0]];

  fetch_stage #(.ADDR_W(ADDR_W), .HLT_OP(7'b1100001)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_imm      (if_id_imm),
    .if_id_pc       (if_id_pc),
    .opcode         (opcode),
    .halted         (halted),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rd(input logic [ADDR_W-1:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  always @(negedge clk or imem_addr) imem_data = rd(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset(input logic [ADDR_W-1:0] vec);
    mem[0] = vec[15:0];
    mem[1] = {12'h000, vec[19:16]};
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    mem.delete();
    mem[0] = 16'h0040; mem[1] = 16'h0000;
    mem[20'h40] = 16'h0200; mem[20'h41] = 16'h0200;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    chk("rst_valid",  {31'b0, if_id_valid}, 32'd0);
    chk("rst_instr",  {16'b0, if_id_instr}, 32'd0);
    chk("rst_imm",    {16'b0, if_id_imm},   32'd0);
    chk("rst_pc",     {12'b0, if_id_pc},    32'd0);
    chk("rst_opcode", {25'b0, opcode},      32'd0);
    chk("rst_halted", {31'b0, halted},      32'd0);
    chk("rst_stallc", stall_cycles,         32'd0);
    chk("rst_addr",   {12'b0, imem_addr},   32'd0);
    reset = 1'b0;
    tick();
    chk("vec1_addr",  {12'b0, imem_addr},   32'd1);
    chk("vec1_valid", {31'b0, if_id_valid}, 32'd0);
    tick();
    chk("vec_pc_addr", {12'b0, imem_addr},  32'h40);
    tick();
    chk("first_valid",  {31'b0, if_id_valid}, 32'd1);
    chk("first_pc",     {12'b0, if_id_pc},    32'h40);
    chk("first_opcode", {25'b0, opcode},      32'd1);
    chk("first_imm",    {16'b0, if_id_imm},   32'd0);
    chk("first_next",   {12'b0, imem_addr},   32'h41);
  endtask

  task automatic test_two_word();
    mem.delete();
    mem[20'h40] = 16'h4005; mem[20'h41] = 16'hBEEF;
    mem[20'h42] = 16'h0200; mem[20'h43] = 16'h4100;
    do_reset(20'h40);
    tick();
    chk("tw_bubble", {31'b0, if_id_valid}, 32'd0);
    chk("tw_addr1",  {12'b0, imem_addr},   32'h41);
    tick();
    chk("tw_valid",  {31'b0, if_id_valid}, 32'd1);
    chk("tw_instr",  {16'b0, if_id_instr}, 32'h4005);
    chk("tw_imm",    {16'b0, if_id_imm},   32'hBEEF);
    chk("tw_pc",     {12'b0, if_id_pc},    32'h40);
    chk("tw_opcode", {25'b0, opcode},      32'h20);
    chk("tw_next",   {12'b0, imem_addr},   32'h42);
    tick();
    chk("tw_add_pc",  {12'b0, if_id_pc},  32'h42);
    chk("tw_add_imm", {16'b0, if_id_imm}, 32'd0);
    tick();
    chk("tw_imm_bub", {31'b0, if_id_valid}, 32'd0);
    reset = 1'b1;
    tick();
    chk("rimm_instr", {16'b0, if_id_instr}, 32'd0);
    chk("rimm_pc",    {12'b0, if_id_pc},    32'd0);
    chk("rimm_opc",   {25'b0, opcode},      32'd0);
    chk("rimm_addr",  {12'b0, imem_addr},   32'd0);
    reset = 1'b0;
  endtask

  task automatic test_stall();
    mem.delete();
    for (int i = 0; i < 6; i++) mem[20'h40 + i] = 16'h0200 + 16'(i);
    do_reset(20'h40);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_valid", {31'b0, if_id_valid}, 32'd1);
      chk("st_instr", {16'b0, if_id_instr}, 32'h0200);
      chk("st_pc",    {12'b0, if_id_pc},    32'h40);
      chk("st_addr",  {12'b0, imem_addr},   32'h41);
    end
    chk("st_count", stall_cycles, EXP_STALL3);
    stall = 1'b0;
    tick();
    chk("st_resume_pc",    {12'b0, if_id_pc},    32'h41);
    chk("st_resume_instr", {16'b0, if_id_instr}, 32'h0201);
  endtask

  task automatic test_redirect_imm();
    mem.delete();
    mem[20'h40] = 16'h4001; mem[20'h41] = 16'h1234;
    mem[20'h100] = 16'h0203; mem[20'h101] = 16'h0200;
    do_reset(20'h40);
    tick();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 20'h100;
    tick();
    chk("rd_valid", {31'b0, if_id_valid}, 32'd0);
    chk("rd_addr",  {12'b0, imem_addr},   32'h100);
    chk("rd_stallc", stall_cycles,        32'd0);
    stall = 1'b0; redirect_valid = 1'b0;
    tick();
    chk("rd_tgt_valid", {31'b0, if_id_valid}, 32'd1);
    chk("rd_tgt_pc",    {12'b0, if_id_pc},    32'h100);
    chk("rd_tgt_instr", {16'b0, if_id_instr}, 32'h0203);
    chk("rd_tgt_imm",   {16'b0, if_id_imm},   32'd0);
  endtask

  task automatic test_halt();
    mem.delete();
    mem[20'h50] = 16'hC200; mem[20'h51] = 16'h0200;
    mem[20'h60] = 16'h0205;
    do_reset(20'h50);
    tick();
    chk("hlt_valid",  {31'b0, if_id_valid}, 32'd1);
    chk("hlt_opcode", {25'b0, opcode},      32'h61);
    chk("hlt_pc",     {12'b0, if_id_pc},    32'h50);
    tick();
    chk("hlt_halted", {31'b0, halted},      32'd1);
    chk("hlt_drop",   {31'b0, if_id_valid}, 32'd0);
    chk("hlt_addr",   {12'b0, imem_addr},   32'h51);
    tick();
    chk("hlt_frozen", {12'b0, imem_addr},   32'h51);
    chk("hlt_still",  {31'b0, halted},      32'd1);
    redirect_valid = 1'b1; redirect_pc = 20'h60;
    tick();
    redirect_valid = 1'b0;
    chk("hlt_exit",   {31'b0, halted},      32'd0);
    chk("hlt_raddr",  {12'b0, imem_addr},   32'h60);
    tick();
    chk("hlt_res_valid", {31'b0, if_id_valid}, 32'd1);
    chk("hlt_res_pc",    {12'b0, if_id_pc},    32'h60);
    chk("hlt_res_instr", {16'b0, if_id_instr}, 32'h0205);
  endtask

  task automatic test_wrap();
    mem.delete();
    mem[20'hFFFFF] = 16'h0207;
    do_reset(20'hFFFFF);
    tick();
    chk("wr_pc",    {12'b0, if_id_pc},    32'hFFFFF);
    chk("wr_instr", {16'b0, if_id_instr}, 32'h0207);
    chk("wr_addr",  {12'b0, imem_addr},   32'd0);
    mem[20'hFFFFF] = 16'h4007;
    do_reset(20'hFFFFF);
    tick();
    chk("wr2_addr", {12'b0, imem_addr}, 32'd0);
    tick();
    chk("wr2_valid", {31'b0, if_id_valid}, 32'd1);
    chk("wr2_pc",    {12'b0, if_id_pc},    32'hFFFFF);
    chk("wr2_imm",   {16'b0, if_id_imm},   32'hFFFF);
    chk("wr2_addr2", {12'b0, imem_addr},   32'd1);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    test_reset();
    test_two_word();
    test_stall();
    test_redirect_imm();
    test_halt();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
